// File: rtl/cache_miss_handler.sv
// Blocking miss handler for a direct-mapped, write-through cache: a read miss
// fetches one word and installs it, and a store is written through to memory.
module cache_miss_handler #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 27,
  parameter int SET_WIDTH  = 3,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_miss,
  input  logic                  wr_req,
  input  logic [DATA_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  fill_en,
  output logic [SET_WIDTH-1:0]  fill_set,
  output logic [TAG_WIDTH-1:0]  fill_tag,
  output logic [DATA_WIDTH-1:0] fill_data,
  output logic                  err
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WRITE,
    FILL,
    ERR
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [DATA_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  fill_en_q, fill_en_d;
  logic [SET_WIDTH-1:0]  fill_set_q, fill_set_d;
  logic [TAG_WIDTH-1:0]  fill_tag_q, fill_tag_d;
  logic [DATA_WIDTH-1:0] fill_data_q, fill_data_d;
  logic                  err_q, err_d;

  // Byte offset is dropped: memory is accessed a word at a time.
  logic unused_byte_offset;
  assign unused_byte_offset = ^cpu_addr[1:0];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    fill_en_d   = 1'b0;
    fill_set_d  = fill_set_q;
    fill_tag_d  = fill_tag_q;
    fill_data_d = fill_data_q;
    err_d       = err_q;

    case (state_q)
      IDLE: begin
        // Read wins a simultaneous request; the held store is taken later.
        if (rd_miss) begin
          state_d    = READ;
          cnt_d      = '0;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = {cpu_addr[DATA_WIDTH-1:2], 2'b00};
        end else if (wr_req) begin
          state_d     = WRITE;
          cnt_d       = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = {cpu_addr[DATA_WIDTH-1:2], 2'b00};
          mem_wdata_d = cpu_wdata;
        end
      end
      READ: begin
        if (mem_ack) begin
          state_d     = FILL;
          mem_req_d   = 1'b0;
          fill_en_d   = 1'b1;
          fill_set_d  = mem_addr_q[2 +: SET_WIDTH];
          fill_tag_d  = mem_addr_q[SET_WIDTH+2 +: TAG_WIDTH];
          fill_data_d = mem_rdata;
        end else if (cnt_q == TIMEOUT_CNT) begin
          state_d   = ERR;
          mem_req_d = 1'b0;
          err_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      WRITE: begin
        if (mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
        end else if (cnt_q == TIMEOUT_CNT) begin
          state_d   = ERR;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          err_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      FILL: begin
        state_d = IDLE;
      end
      ERR: begin
        err_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      fill_en_q   <= 1'b0;
      fill_set_q  <= '0;
      fill_tag_q  <= '0;
      fill_data_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      fill_en_q   <= fill_en_d;
      fill_set_q  <= fill_set_d;
      fill_tag_q  <= fill_tag_d;
      fill_data_q <= fill_data_d;
      err_q       <= err_d;
    end
  end

  // Stall is raised combinationally so the request cycle itself is held.
  assign stall     = (state_q != IDLE) | rd_miss | wr_req;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign fill_en   = fill_en_q;
  assign fill_set  = fill_set_q;
  assign fill_tag  = fill_tag_q;
  assign fill_data = fill_data_q;
  assign err       = err_q;

endmodule
